// File: rtl/circle_render_pkg.sv
// Shared types, default-configuration widths and the approach-circle state
// encoding for the playfield circle renderer.
package circle_render_pkg;

   localparam int CR_COORD_W    = 10;
   localparam int CR_MAX_RADIUS = 48;
   localparam int CR_RAD_W      = $clog2(CR_MAX_RADIUS + 1);
   localparam int CR_SDIST_W    = CR_COORD_W + 1;
   localparam int CR_DIST2_W    = 2 * CR_COORD_W + 2;

   typedef logic        [CR_COORD_W-1:0] coord_t;
   typedef logic signed [CR_SDIST_W-1:0] sdist_t;
   typedef logic        [CR_DIST2_W-1:0] dist2_t;
   typedef logic        [CR_RAD_W-1:0]   radius_t;

   typedef enum logic {AP_IDLE, AP_SHRINK} ap_state_e;

   // Index width that stays legal for a single-channel build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/circle_hit_test.sv
// One object channel: registers the signed offset to the pixel, then compares
// the squared distance against the body circle and the approach ring.
module circle_hit_test
   import circle_render_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int RAD_W   = 6,
   parameter int RING_W  = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [COORD_W-1:0] draw_x_i,
   input  logic [COORD_W-1:0] draw_y_i,
   input  logic [COORD_W-1:0] obj_x_i,
   input  logic [COORD_W-1:0] obj_y_i,
   input  logic [RAD_W-1:0]   radius_i,
   input  logic               valid_i,
   input  logic               ring_i,
   input  logic               app_active_i,
   input  logic [RAD_W-1:0]   app_radius_i,
   output logic               body_hit_o,
   output logic               app_hit_o
);

   localparam int SW  = COORD_W + 1;
   localparam int D2W = 2 * COORD_W + 2;
   localparam int R2W = 2 * RAD_W;

   logic signed [SW-1:0]  dx_d, dy_d, dx_q, dy_q;
   logic signed [D2W-1:0] ex_x, ex_y, sq_x, sq_y;
   logic        [D2W-1:0] d2;

   // One extra bit keeps DrawX=0 against x=max from wrapping.
   assign dx_d = $signed({1'b0, draw_x_i}) - $signed({1'b0, obj_x_i});
   assign dy_d = $signed({1'b0, draw_y_i}) - $signed({1'b0, obj_y_i});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dx_q <= '0;
         dy_q <= '0;
      end else begin
         dx_q <= dx_d;
         dy_q <= dy_d;
      end
   end

   assign ex_x = D2W'(dx_q);
   assign ex_y = D2W'(dy_q);
   assign sq_x = ex_x * ex_x;
   assign sq_y = ex_y * ex_y;
   assign d2   = $unsigned(sq_x) + $unsigned(sq_y);

   // Inside radius r; for a ring also strictly outside r-RING_W, unless the
   // ring is at least as thick as the circle, which degenerates to a disc.
   function automatic logic in_band(input logic [D2W-1:0] dist2,
                                    input logic [RAD_W-1:0] r,
                                    input logic ring);
      logic [R2W-1:0]   outer;
      logic [R2W-1:0]   inner;
      logic [RAD_W-1:0] r_in;
      outer   = R2W'(r) * R2W'(r);
      r_in    = r - RAD_W'(RING_W);
      inner   = R2W'(r_in) * R2W'(r_in);
      in_band = (dist2 <= D2W'(outer)) &&
                (!ring || (r <= RAD_W'(RING_W)) || (dist2 > D2W'(inner)));
   endfunction

   assign body_hit_o = valid_i & in_band(d2, radius_i, ring_i);
   assign app_hit_o  = app_active_i & in_band(d2, app_radius_i, 1'b1);

endmodule

// File: rtl/circle_renderer.sv
// Multi-object circle renderer: frame-latched geometry, per-channel hit test,
// lowest-index priority and 2-cycle pixel latency.
// Define CIRCLE_RENDERER_APPROACH_EN to build the shrinking approach circles.
module circle_renderer
   import circle_render_pkg::*;
#(
   parameter  int N_OBJ       = 4,
   parameter  int COORD_W     = 10,
   parameter  int MAX_RADIUS  = 48,
   parameter  int RING_W      = 2,
   parameter  int SHRINK_STEP = 1,
   localparam int RAD_W       = $clog2(MAX_RADIUS + 1),
   localparam int IDX_W       = idx_width(N_OBJ)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     frame_clk,
   input  logic [COORD_W-1:0]       DrawX,
   input  logic [COORD_W-1:0]       DrawY,
   input  logic [N_OBJ*COORD_W-1:0] obj_x,
   input  logic [N_OBJ*COORD_W-1:0] obj_y,
   input  logic [N_OBJ*RAD_W-1:0]   obj_radius,
   input  logic [N_OBJ-1:0]         obj_valid,
   input  logic [N_OBJ-1:0]         obj_ring,
   input  logic [N_OBJ-1:0]         spawn,
   output logic                     is_obj,
   output logic [IDX_W-1:0]         obj_idx,
   output logic                     is_approach,
   output logic [N_OBJ-1:0]         approach_done
);

   logic               frame_q, frame_prev_q, fe;
   logic [COORD_W-1:0] sx_q [N_OBJ];
   logic [COORD_W-1:0] sy_q [N_OBJ];
   logic [RAD_W-1:0]   sr_q [N_OBJ];
   logic [N_OBJ-1:0]   sv_q, sring_q;
   logic [RAD_W-1:0]   app_r [N_OBJ];
   logic [N_OBJ-1:0]   app_active, body_hit, app_hit;
   logic               hit_d, hit_q, app_sel_d, app_sel_q;
   logic [IDX_W-1:0]   idx_d, idx_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_q      <= 1'b0;
         frame_prev_q <= 1'b0;
      end else begin
         frame_q      <= frame_clk;
         frame_prev_q <= frame_q;
      end
   end

   assign fe = frame_q & ~frame_prev_q;

   // Shadow geometry only moves on a frame edge so a frame never tears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_OBJ; i++) begin
            sx_q[i] <= '0;
            sy_q[i] <= '0;
            sr_q[i] <= '0;
         end
         sv_q    <= '0;
         sring_q <= '0;
      end else if (fe) begin
         for (int i = 0; i < N_OBJ; i++) begin
            sx_q[i] <= obj_x[i*COORD_W +: COORD_W];
            sy_q[i] <= obj_y[i*COORD_W +: COORD_W];
            sr_q[i] <= (obj_radius[i*RAD_W +: RAD_W] > RAD_W'(MAX_RADIUS)) ?
                       RAD_W'(MAX_RADIUS) : obj_radius[i*RAD_W +: RAD_W];
         end
         sv_q    <= obj_valid;
         sring_q <= obj_ring;
      end
   end

`ifdef CIRCLE_RENDERER_APPROACH_EN
   localparam int AW = RAD_W + 2;

   ap_state_e        ap_st_q [N_OBJ];
   ap_state_e        ap_st_d [N_OBJ];
   logic [RAD_W-1:0] ar_q [N_OBJ];
   logic [RAD_W-1:0] ar_d [N_OBJ];
   logic [N_OBJ-1:0] done_d, done_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_OBJ; i++) begin
            ap_st_q[i] <= AP_IDLE;
            ar_q[i]    <= '0;
         end
         done_q <= '0;
      end else begin
         for (int i = 0; i < N_OBJ; i++) begin
            ap_st_q[i] <= ap_st_d[i];
            ar_q[i]    <= ar_d[i];
         end
         done_q <= done_d;
      end
   end

   // A spawn outranks a coincident frame edge: the ring restarts at full size.
   always_comb begin
      for (int i = 0; i < N_OBJ; i++) begin
         ap_st_d[i] = ap_st_q[i];
         ar_d[i]    = ar_q[i];
         done_d[i]  = 1'b0;
         if (spawn[i] && sv_q[i]) begin
            ap_st_d[i] = AP_SHRINK;
            ar_d[i]    = RAD_W'(MAX_RADIUS);
         end else if (ap_st_q[i] == AP_SHRINK) begin
            if (!sv_q[i]) begin
               ap_st_d[i] = AP_IDLE;
            end else if (fe) begin
               if ({2'b00, ar_q[i]} <= ({2'b00, sr_q[i]} + AW'(SHRINK_STEP))) begin
                  ar_d[i]    = sr_q[i];
                  done_d[i]  = 1'b1;
                  ap_st_d[i] = AP_IDLE;
               end else begin
                  ar_d[i] = ar_q[i] - RAD_W'(SHRINK_STEP);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_OBJ; i++) begin
         app_active[i] = (ap_st_q[i] == AP_SHRINK);
         app_r[i]      = ar_q[i];
      end
   end

   assign approach_done = done_q;
`else
   logic unused_ok;
   assign unused_ok = ^{spawn, 32'(SHRINK_STEP)};

   always_comb begin
      for (int i = 0; i < N_OBJ; i++) begin
         app_active[i] = 1'b0;
         app_r[i]      = '0;
      end
   end

   assign approach_done = '0;
`endif

   for (genvar g = 0; g < N_OBJ; g++) begin : g_ch
      circle_hit_test #(
         .COORD_W (COORD_W),
         .RAD_W   (RAD_W),
         .RING_W  (RING_W)
      ) u_hit (
         .clk_i        (Clk),
         .rst_i        (Reset),
         .draw_x_i     (DrawX),
         .draw_y_i     (DrawY),
         .obj_x_i      (sx_q[g]),
         .obj_y_i      (sy_q[g]),
         .radius_i     (sr_q[g]),
         .valid_i      (sv_q[g]),
         .ring_i       (sring_q[g]),
         .app_active_i (app_active[g]),
         .app_radius_i (app_r[g]),
         .body_hit_o   (body_hit[g]),
         .app_hit_o    (app_hit[g])
      );
   end

   // Scan high to low so the lowest-numbered hitting channel is left standing.
   always_comb begin
      hit_d     = 1'b0;
      idx_d     = '0;
      app_sel_d = 1'b0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (body_hit[i] || app_hit[i]) begin
            hit_d     = 1'b1;
            idx_d     = IDX_W'(i);
            app_sel_d = ~body_hit[i];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit_q     <= 1'b0;
         idx_q     <= '0;
         app_sel_q <= 1'b0;
      end else begin
         hit_q     <= hit_d;
         idx_q     <= idx_d;
         app_sel_q <= app_sel_d;
      end
   end

   assign is_obj      = hit_q;
   assign obj_idx     = idx_q;
   assign is_approach = app_sel_q;

endmodule

// File: tb/tb_circle_renderer.sv
// Directed bench for circle_renderer: a behavioural model of the latched
// geometry pushes expected pixel results that are popped two cycles later.
module tb_circle_renderer;
   import circle_render_pkg::*;

`ifdef CIRCLE_RENDERER_APPROACH_EN
   localparam bit APP_EN = 1'b1;
`else
   localparam bit APP_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   coord_t      DrawX, DrawY;
   logic [39:0] obj_x, obj_y;
   logic [23:0] obj_radius;
   logic [3:0]  obj_valid, obj_ring, spawn;
   logic        is_obj;
   logic [1:0]  obj_idx;
   logic        is_approach;
   logic [3:0]  approach_done;

   circle_renderer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .obj_x         (obj_x),
      .obj_y         (obj_y),
      .obj_radius    (obj_radius),
      .obj_valid     (obj_valid),
      .obj_ring      (obj_ring),
      .spawn         (spawn),
      .is_obj        (is_obj),
      .obj_idx       (obj_idx),
      .is_approach   (is_approach),
      .approach_done (approach_done)
   );

   always #10 Clk = ~Clk;

   int n_pass = 0;
   int n_total = 0;
   int done_total = 0;
   int exp_done_total = 0;

   // model of the shadow geometry and approach rings
   int   m_x [4];
   int   m_y [4];
   int   m_r [4];
   int   m_ar [4];
   logic m_v [4];
   logic m_ring [4];
   logic m_act [4];

   logic [3:0] exp_q [$];

   always @(negedge Clk) done_total += $countones(approach_done);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_r[i] = 0; m_ar[i] = 0;
         m_v[i] = 1'b0; m_ring[i] = 1'b0; m_act[i] = 1'b0;
      end
   endtask

   // {is_obj, obj_idx, is_approach}
   function automatic logic [3:0] model_px(input int px, input int py);
      int dx, dy, d2, r, ar;
      logic body, app;
      model_px = 4'b0000;
      for (int i = 3; i >= 0; i--) begin
         dx = px - m_x[i];
         dy = py - m_y[i];
         d2 = dx * dx + dy * dy;
         r  = m_r[i];
         ar = m_ar[i];
         body = m_v[i] && (d2 <= r * r) && (!m_ring[i] || r <= 2 || d2 > (r - 2) * (r - 2));
         app  = APP_EN && m_act[i] && (d2 <= ar * ar) && (ar <= 2 || d2 > (ar - 2) * (ar - 2));
         if (body || app) model_px = {1'b1, 2'(i), !body};
      end
   endfunction

   task automatic set_obj(input int i, input int x, input int y, input int r,
                          input logic v, input logic ring);
      obj_x[i*10 +: 10]     = 10'(x);
      obj_y[i*10 +: 10]     = 10'(y);
      obj_radius[i*6 +: 6]  = 6'(r);
      obj_valid[i]          = v;
      obj_ring[i]           = ring;
   endtask

   task automatic px(input int x, input int y);
      @(negedge Clk);
      if (exp_q.size() == 2) chk("pix", 32'({is_obj, obj_idx, is_approach}), 32'(exp_q.pop_front()));
      DrawX = 10'(x);
      DrawY = 10'(y);
      exp_q.push_back(model_px(x, y));
   endtask

   task automatic flush();
      @(negedge Clk);
      if (exp_q.size() == 2) chk("pix", 32'({is_obj, obj_idx, is_approach}), 32'(exp_q.pop_front()));
      @(negedge Clk);
      if (exp_q.size() >= 1) chk("pix", 32'({is_obj, obj_idx, is_approach}), 32'(exp_q.pop_front()));
   endtask

   task automatic do_spawn(input logic [3:0] sp);
      @(negedge Clk) spawn = sp;
      @(negedge Clk) spawn = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (sp[i] && m_v[i]) begin m_act[i] = 1'b1; m_ar[i] = 48; end
   endtask

   // One frame strobe; sp is pulsed in the same cycle as the detected edge.
   task automatic do_frame(input logic [3:0] sp);
      logic [3:0] exp_done;
      int rr;
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) begin frame_clk = 1'b0; spawn = sp; end
      @(negedge Clk) spawn = 4'b0000;
      exp_done = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (sp[i] && m_v[i]) begin
            m_act[i] = 1'b1; m_ar[i] = 48;
         end else if (m_act[i]) begin
            if (m_ar[i] - 1 <= m_r[i]) begin
               m_ar[i] = m_r[i]; m_act[i] = 1'b0; exp_done[i] = APP_EN;
            end else begin
               m_ar[i] = m_ar[i] - 1;
            end
         end
         m_x[i]    = int'(obj_x[i*10 +: 10]);
         m_y[i]    = int'(obj_y[i*10 +: 10]);
         rr        = int'(obj_radius[i*6 +: 6]);
         m_r[i]    = (rr > 48) ? 48 : rr;
         m_v[i]    = obj_valid[i];
         m_ring[i] = obj_ring[i];
         if (!m_v[i]) m_act[i] = 1'b0;
      end
      exp_done_total += $countones(exp_done);
      chk("done", 32'(approach_done), 32'(exp_done));
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
      obj_x = '0; obj_y = '0; obj_radius = '0; obj_valid = '0; obj_ring = '0; spawn = '0;
      model_reset();
      repeat (3) @(negedge Clk);
      chk("rst_out", 32'({is_obj, obj_idx, is_approach}), 32'(0));
      chk("rst_done", 32'(approach_done), 32'(0));
      Reset = 1'b0;

      // filled disc r=4 at (100,100)
      set_obj(0, 100, 100, 4, 1'b1, 1'b0);
      do_frame(4'b0000);
      px(104, 100); px(105, 100); px(100, 96); px(103, 103); px(100, 100);
      flush();

      // reset mid-frame with a live hit, then no hit until the next frame edge
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) chk("rst_mid", 32'({is_obj, obj_idx, is_approach}), 32'(0));
      Reset = 1'b0;
      model_reset();
      px(100, 100); px(104, 100);
      flush();
      do_frame(4'b0000);
      px(100, 100);
      flush();

      // ring r=10: inner edge exclusive, outer edge inclusive
      set_obj(0, 100, 100, 10, 1'b1, 1'b1);
      do_frame(4'b0000);
      px(109, 100); px(107, 100); px(108, 100); px(110, 100); px(111, 100);
      flush();
      set_obj(0, 100, 100, 2, 1'b1, 1'b1);
      do_frame(4'b0000);
      px(100, 100); px(102, 100); px(103, 100);
      flush();

      // priority and frame latching
      set_obj(0, 400, 400, 5, 1'b1, 1'b0);
      set_obj(1, 200, 200, 5, 1'b1, 1'b0);
      set_obj(3, 202, 200, 5, 1'b1, 1'b0);
      do_frame(4'b0000);
      px(200, 200); px(205, 200); px(207, 200);
      flush();
      set_obj(1, 300, 200, 5, 1'b1, 1'b0);
      px(200, 200);
      flush();
      do_frame(4'b0000);
      px(200, 200); px(300, 200);
      flush();

      // radius clamp at latch
      set_obj(0, 600, 600, 60, 1'b1, 1'b0);
      do_frame(4'b0000);
      px(648, 600); px(649, 600);
      flush();

      // approach circle on channel 2, r=40
      set_obj(0, 0, 0, 0, 1'b0, 1'b0);
      set_obj(1, 0, 0, 0, 1'b0, 1'b0);
      set_obj(3, 0, 0, 0, 1'b0, 1'b0);
      set_obj(2, 500, 300, 40, 1'b1, 1'b0);
      do_frame(4'b0000);
      do_spawn(4'b0001);
      do_spawn(4'b0100);
      px(548, 300); px(540, 300); px(546, 300); px(547, 300); px(549, 300);
      flush();
      for (int k = 0; k < 8; k++) do_frame(4'b0000);
      px(548, 300);
      flush();
      do_frame(4'b0100);
      px(548, 300); px(547, 300);
      flush();
      do_frame(4'b0000);
      px(548, 300); px(547, 300);
      flush();
      set_obj(2, 500, 300, 40, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) do_frame(4'b0000);
      px(547, 300); px(500, 300);
      flush();

      // coordinate corners and exact-boundary hits
      set_obj(1, 1023, 5, 2, 1'b1, 1'b0);
      set_obj(3, 0, 0, 5, 1'b1, 1'b0);
      do_frame(4'b0000);
      px(0, 5); px(1023, 5); px(1021, 5); px(3, 4); px(4, 4); px(1, 5);
      flush();

      repeat (2) @(negedge Clk);
      chk("done_total", 32'(done_total), 32'(exp_done_total));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
